// File: rtl/knn_point_streamer.sv
// knn_point_streamer: feeds N dataset points and the test point to the KNN sorter, then sweeps SEL to collect K results.
// Build with KNN_STREAMER_PERF_EN to add a saturating 32-bit run-cycle counter output.
module knn_point_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IDX_W = 8,
  parameter int K = 4,
  parameter int GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         n_points,
  input  logic signed [DATA_W-1:0]  test_x,
  input  logic signed [DATA_W-1:0]  test_y,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic signed [DATA_W-1:0]  mem_x,
  input  logic signed [DATA_W-1:0]  mem_y,
  output logic signed [DATA_W-1:0]  DATA_X1,
  output logic signed [DATA_W-1:0]  DATA_Y1,
  output logic signed [DATA_W-1:0]  DATA_X2,
  output logic signed [DATA_W-1:0]  DATA_Y2,
  output logic                      ready,
  output logic                      DONE,
  output logic [$clog2(K)-1:0]      SEL,
  input  logic [IDX_W-1:0]          DATA_OUT,
  output logic [K*IDX_W-1:0]        res_idx,
  output logic                      busy,
  output logic                      fin
`ifdef KNN_STREAMER_PERF_EN
  ,output logic [31:0]              cycles
`endif
);
  localparam int SW = $clog2(K);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SEND, GAPW, FLUSH, READ, FIN} state_t;
  state_t r_state;
  logic [ADDR_W-1:0] r_n, r_p;
  logic [GW-1:0] r_g;
  logic [SW-1:0] r_j;
  logic r_rd;
  logic [ADDR_W-1:0] w_p_next;
  assign w_p_next = r_p + 1'b1;
  // Outputs are registered from the current state, so each output trails its state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_n <= '0;
      r_p <= '0;
      r_g <= '0;
      r_j <= '0;
      r_rd <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      DATA_X1 <= '0;
      DATA_Y1 <= '0;
      DATA_X2 <= '0;
      DATA_Y2 <= '0;
      ready <= 1'b0;
      DONE <= 1'b0;
      SEL <= '0;
      res_idx <= '0;
      busy <= 1'b0;
      fin <= 1'b0;
    end else begin
      mem_rd <= r_state == LOAD;
      ready <= r_state == SEND;
      busy <= r_state != IDLE;
      fin <= r_state == FIN;
      r_rd <= r_state == READ;
      if (r_rd) res_idx[SEL*IDX_W +: IDX_W] <= DATA_OUT;
      case (r_state)
        IDLE: if (start) begin
          r_n <= n_points;
          r_p <= '0;
          DATA_X1 <= test_x;
          DATA_Y1 <= test_y;
          DONE <= 1'b0;
          r_state <= n_points == '0 ? FLUSH : LOAD;
        end
        LOAD: begin
          mem_addr <= r_p;
          r_state <= WAIT;
        end
        WAIT: r_state <= SEND;
        SEND: begin
          DATA_X2 <= mem_x;
          DATA_Y2 <= mem_y;
          r_p <= w_p_next;
          r_g <= '0;
          r_state <= GAP > 0 ? GAPW : (w_p_next == r_n ? FLUSH : LOAD);
        end
        GAPW: begin
          r_g <= r_g + 1'b1;
          if (r_g == GW'(GAP - 1)) r_state <= r_p == r_n ? FLUSH : LOAD;
        end
        FLUSH: begin
          DONE <= 1'b1;
          SEL <= '0;
          r_j <= '0;
          r_state <= READ;
        end
        READ: begin
          SEL <= r_j;
          r_j <= r_j + 1'b1;
          if (r_j == SW'(K - 1)) r_state <= FIN;
        end
        FIN: begin
          SEL <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef KNN_STREAMER_PERF_EN
  // Acceptance cycle counts as the first cycle; FIN cycle is the last one counted.
  always_ff @(posedge clk) begin
    if (!rst) cycles <= '0;
    else if (r_state == IDLE) cycles <= start ? 32'd1 : cycles;
    else if (~&cycles) cycles <= cycles + 32'd1;
  end
`endif
endmodule
